// File: rtl/ast_packet_mux.sv
// rtl/ast_packet_mux.sv - round-robin, packet-granular Avalon-ST multiplexer with registered output
module ast_packet_mux #(
    parameter int DATA_WIDTH    = 64,
    parameter int EMPTY_WIDTH   = 3,
    parameter int CHANNEL_WIDTH = 8,
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic [RX_DIR*DATA_WIDTH-1:0]      ast_data_i,
    input  logic [RX_DIR-1:0]                 ast_startofpacket_i,
    input  logic [RX_DIR-1:0]                 ast_endofpacket_i,
    input  logic [RX_DIR-1:0]                 ast_valid_i,
    input  logic [RX_DIR*EMPTY_WIDTH-1:0]     ast_empty_i,
    input  logic [RX_DIR*CHANNEL_WIDTH-1:0]   ast_channel_i,
    output logic [RX_DIR-1:0]                 ast_ready_o,
    output logic [DATA_WIDTH-1:0]             ast_data_o,
    output logic                              ast_startofpacket_o,
    output logic                              ast_endofpacket_o,
    output logic                              ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]            ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0]          ast_channel_o,
    output logic [DIR_SEL_WIDTH-1:0]          dir_o,
    input  logic                              ast_ready_i
);
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DIR_SEL_WIDTH-1:0]   r_sel;
    logic [DIR_SEL_WIDTH-1:0]   r_last_grant;
    logic [DIR_SEL_WIDTH-1:0]   w_pick;
    logic [DIR_SEL_WIDTH-1:0]   w_cand;
    logic                       w_pick_vld;
    logic                       w_accept;

    logic [DATA_WIDTH-1:0]      w_sel_data;
    logic [EMPTY_WIDTH-1:0]     w_sel_empty;
    logic [CHANNEL_WIDTH-1:0]   w_sel_channel;

    logic [DATA_WIDTH-1:0]      r_data;
    logic                       r_sop;
    logic                       r_eop;
    logic                       r_valid;
    logic [EMPTY_WIDTH-1:0]     r_empty;
    logic [CHANNEL_WIDTH-1:0]   r_channel;
    logic [DIR_SEL_WIDTH-1:0]   r_dir;

    assign w_sel_data    = ast_data_i[r_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_empty   = ast_empty_i[r_sel*EMPTY_WIDTH +: EMPTY_WIDTH];
    assign w_sel_channel = ast_channel_i[r_sel*CHANNEL_WIDTH +: CHANNEL_WIDTH];

    // Scan starts just after the last winner so every input gets a turn.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_cand     = '0;
        for (int k = 1; k <= RX_DIR; k++) begin
            w_cand = DIR_SEL_WIDTH'((int'(r_last_grant) + k) % RX_DIR);
            if (!w_pick_vld && ast_valid_i[w_cand] && ast_startofpacket_i[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_cand;
            end
        end
    end

    assign w_accept = (r_state == ST_BUSY) && ast_valid_i[r_sel] && ast_ready_o[r_sel];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_vld) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_accept && ast_endofpacket_i[r_sel]) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // In IDLE only beats without SOP are taken, and only to be discarded.
    always_comb begin
        ast_ready_o = '0;
        if (!srst) begin
            case (r_state)
                ST_IDLE: ast_ready_o = ast_valid_i & ~ast_startofpacket_i;
                ST_BUSY: ast_ready_o[r_sel] = !r_valid || ast_ready_i;
                default: ast_ready_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_sel        <= '0;
            r_last_grant <= DIR_SEL_WIDTH'(RX_DIR - 1);
        end else if (r_state == ST_IDLE && w_pick_vld) begin
            r_sel        <= w_pick;
            r_last_grant <= w_pick;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_data    <= '0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_valid   <= 1'b0;
            r_empty   <= '0;
            r_channel <= '0;
            r_dir     <= '0;
        end else if (w_accept) begin
            r_data    <= w_sel_data;
            r_sop     <= ast_startofpacket_i[r_sel];
            r_eop     <= ast_endofpacket_i[r_sel];
            r_valid   <= 1'b1;
            r_empty   <= ast_endofpacket_i[r_sel] ? w_sel_empty : '0;
            r_channel <= w_sel_channel;
            r_dir     <= r_sel;
        end else if (ast_ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    assign ast_data_o          = r_data;
    assign ast_startofpacket_o = r_sop;
    assign ast_endofpacket_o   = r_eop;
    assign ast_valid_o         = r_valid;
    assign ast_empty_o         = r_empty;
    assign ast_channel_o       = r_channel;
    assign dir_o               = r_dir;
endmodule

// File: tb/tb_ast_packet_mux.sv
// tb/tb_ast_packet_mux.sv - randomized and directed bench for ast_packet_mux against a packet-queue model
module tb_ast_packet_mux;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int CW = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              srst = 1'b1;
    logic [N*DW-1:0]   ast_data_i = '0;
    logic [N-1:0]      ast_startofpacket_i = '0;
    logic [N-1:0]      ast_endofpacket_i = '0;
    logic [N-1:0]      ast_valid_i = '0;
    logic [N*EW-1:0]   ast_empty_i = '0;
    logic [N*CW-1:0]   ast_channel_i = '0;
    logic [N-1:0]      ast_ready_o;
    logic [DW-1:0]     ast_data_o;
    logic              ast_startofpacket_o;
    logic              ast_endofpacket_o;
    logic              ast_valid_o;
    logic [EW-1:0]     ast_empty_o;
    logic [CW-1:0]     ast_channel_o;
    logic [SW-1:0]     dir_o;
    logic              ast_ready_i = 1'b1;

    always #5 clk = ~clk;

    ast_packet_mux #(
        .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .RX_DIR(N), .DIR_SEL_WIDTH(SW)
    ) dut (
        .clk(clk), .srst(srst),
        .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
        .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
        .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i), .ast_ready_o(ast_ready_o),
        .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
        .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
        .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o), .dir_o(dir_o),
        .ast_ready_i(ast_ready_i)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [CW-1:0] chan;
    } beat_t;

    typedef struct {
        beat_t         b;
        logic [SW-1:0] dir;
        int            cyc;
    } obs_t;

    // Per-input stimulus, per-input expected output packets, and the observed output log.
    beat_t in_q[N][$];
    beat_t exp_q[N][$];
    obs_t  log_q[$];

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic          in_pkt = 1'b0;
    logic [SW-1:0] cur_dir = '0;
    logic [N-1:0]  last_rdy = '0;
    logic          hold_pend = 1'b0;
    beat_t         hold_b;
    logic [SW-1:0] hold_dir;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t cur_out();
        beat_t b;
        b.data  = ast_data_o;
        b.sop   = ast_startofpacket_o;
        b.eop   = ast_endofpacket_o;
        b.empty = ast_empty_o;
        b.chan  = ast_channel_o;
        return b;
    endfunction

    function automatic logic [SW-1:0] dir_at(input int k);
        if (k < log_q.size()) return log_q[k].dir;
        return 'x;
    endfunction

    function automatic int cyc_at(input int k);
        if (k < log_q.size()) return log_q[k].cyc;
        return -1;
    endfunction

    task automatic push_pkt(input int i, input int len, input logic [EW-1:0] emp, input logic [CW-1:0] ch);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data  = {$urandom, $urandom};
            x.sop   = (b == 0);
            x.eop   = (b == len - 1);
            x.empty = x.eop ? emp : EW'($urandom_range(7));
            x.chan  = ch;
            in_q[i].push_back(x);
            if (!x.eop) x.empty = '0;
            exp_q[i].push_back(x);
        end
    endtask

    task automatic push_garbage(input int i);
        beat_t x;
        x.data  = {$urandom, $urandom};
        x.sop   = 1'b0;
        x.eop   = 1'($urandom_range(1));
        x.empty = EW'($urandom_range(7));
        x.chan  = CW'($urandom);
        in_q[i].push_back(x);
    endtask

    task automatic score(input beat_t ob, input logic [SW-1:0] od);
        if (ob.sop) begin
            check("no_interleave", in_pkt, 1'b0);
            in_pkt  = 1'b1;
            cur_dir = od;
        end else begin
            check("pkt_continuity", {in_pkt, od}, {1'b1, cur_dir});
        end
        check("exp_avail", exp_q[od].size() > 0, 1'b1);
        if (exp_q[od].size() > 0) check("beat", ob, exp_q[od].pop_front());
        if (ob.eop) in_pkt = 1'b0;
        log_q.push_back('{b: ob, dir: od, cyc: cyc});
    endtask

    // One clock: drive queue heads (valid with probability vprob), rmode 0/1 fixed ready, 2 random.
    task automatic cycle(input int vprob, input int rmode);
        logic [N-1:0]  take;
        logic          out_take;
        beat_t         ob;
        logic [SW-1:0] od;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (in_q[i].size() > 0 && int'($urandom_range(99)) < vprob) begin
                ast_valid_i[i]            = 1'b1;
                ast_data_i[i*DW +: DW]    = in_q[i][0].data;
                ast_startofpacket_i[i]    = in_q[i][0].sop;
                ast_endofpacket_i[i]      = in_q[i][0].eop;
                ast_empty_i[i*EW +: EW]   = in_q[i][0].empty;
                ast_channel_i[i*CW +: CW] = in_q[i][0].chan;
            end else begin
                ast_valid_i[i]         = 1'b0;
                ast_startofpacket_i[i] = 1'b0;
                ast_endofpacket_i[i]   = 1'b0;
            end
        end
        ast_ready_i = (rmode == 2) ? (int'($urandom_range(99)) < 75) : (rmode != 0);
        #1;
        ob = cur_out();
        od = dir_o;
        if (hold_pend) check("hold", {ob, od, ast_valid_o}, {hold_b, hold_dir, 1'b1});
        hold_pend = ast_valid_o && !ast_ready_i;
        hold_b    = ob;
        hold_dir  = od;
        take      = ast_valid_i & ast_ready_o;
        out_take  = ast_valid_o & ast_ready_i;
        last_rdy  = ast_ready_o;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++) if (take[i]) void'(in_q[i].pop_front());
        if (out_take) score(ob, od);
    endtask

    task automatic drain(input string tag, input int vprob, input int rmode, input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            cycle(vprob, rmode);
            n++;
            done = !in_pkt;
            for (int i = 0; i < N; i++) if (in_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
        end
        check({tag, "_drain"}, done, 1'b1);
    endtask

    // Holds srst for ncyc edges with valid-without-SOP on every input, then checks all outputs are 0.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        srst                = 1'b1;
        ast_valid_i         = '1;
        ast_startofpacket_i = '0;
        ast_ready_i         = 1'b1;
        repeat (ncyc) @(negedge clk);
        #1;
        check("rst_outputs",
              {ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_valid_o,
               ast_empty_o, ast_channel_o, dir_o}, '0);
        srst        = 1'b0;
        ast_valid_i = '0;
        for (int i = 0; i < N; i++) begin
            in_q[i].delete();
            exp_q[i].delete();
        end
        in_pkt    = 1'b0;
        hold_pend = 1'b0;
    endtask

    initial begin
        int s;
        int c0;
        int n;
        int pat[4];
        logic [15:0] seq;
        pat = '{1, 0, 0, 1};

        do_reset(3);

        // Three-beat packet on input 0 at full rate.
        push_pkt(0, 3, 3'd5, 8'h11);
        s  = log_q.size();
        c0 = cyc;
        drain("t2", 100, 1, 50);
        check("t2_count", log_q.size() - s, 3);
        check("t2_latency", cyc_at(s) - c0, 3);
        check("t2_consec", cyc_at(s + 2) - cyc_at(s), 2);
        check("t2_dir", {dir_at(s), dir_at(s + 1), dir_at(s + 2)}, 6'd0);

        // Make input 1 the last winner, then race inputs 1 and 3.
        push_pkt(1, 1, 3'd2, 8'h21);
        drain("t3a", 100, 1, 50);
        push_pkt(1, 2, 3'd1, 8'h22);
        push_pkt(3, 2, 3'd7, 8'h33);
        s = log_q.size();
        drain("t3", 100, 1, 50);
        check("t3_order", {dir_at(s), dir_at(s + 2)}, {2'd3, 2'd1});

        // Single-beat packets on every input after reset: rotation from 0, two cycles apiece.
        do_reset(1);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_pkt(i, 1, EW'(i), CW'(8'h40 + i));
        s = log_q.size();
        drain("t4", 100, 1, 60);
        seq = '0;
        for (int k = 0; k < 8; k++) seq = {seq[13:0], dir_at(s + k)};
        check("t4_order", seq, 16'h1B1B);
        check("t4_spacing", cyc_at(s + 7) - cyc_at(s), 14);

        // Output backpressure pattern mid-packet.
        push_pkt(0, 4, 3'd3, 8'h55);
        s = log_q.size();
        for (int k = 0; k < 8; k++) cycle(100, pat[k % 4]);
        drain("t5", 100, 1, 50);
        check("t5_count", log_q.size() - s, 4);

        // Valid without SOP while idle is swallowed.
        push_garbage(2);
        s = log_q.size();
        cycle(100, 1);
        check("t6_ready", last_rdy, 4'b0100);
        repeat (3) cycle(100, 1);
        check("t6_dropped", in_q[2].size(), 0);
        check("t6_no_out", log_q.size() - s, 0);

        // Reset on the third beat of a four-beat packet; input 0 then wins first.
        push_pkt(0, 4, 3'd6, 8'h66);
        n = 0;
        while (in_q[0].size() > 2 && n < 50) begin
            cycle(100, 1);
            n++;
        end
        check("t7_reach", in_q[0].size(), 2);
        do_reset(1);
        push_pkt(0, 1, 3'd1, 8'h70);
        push_pkt(1, 1, 3'd2, 8'h71);
        s = log_q.size();
        drain("t7", 100, 1, 50);
        check("t7_order", {dir_at(s), dir_at(s + 1)}, {2'd0, 2'd1});

        // Random traffic with gaps, stray beats and random backpressure.
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 5; p++) begin
                if ($urandom_range(3) == 0) push_garbage(i);
                push_pkt(i, int'($urandom_range(1, 5)), EW'($urandom), CW'($urandom));
            end
        drain("t8", 70, 2, 5000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ast_packet_mux.md
Name: ast_packet_mux

Overview:
- Avalon-ST packet multiplexer. It merges RX_DIR input streams into one output stream.
- It sits directly downstream of the per-direction outputs of the stream demux and recombines them onto a single link.
- Arbitration is round-robin at packet granularity. Once a packet starts on an input, that input owns the output until its endofpacket beat is transferred.
- The output side is registered and tracks the output ready signal beat by beat.

Parameters:
- DATA_WIDTH, 64, width of ast_data on every port.
- EMPTY_WIDTH, 3, width of ast_empty; equals clog2(DATA_WIDTH/8).
- CHANNEL_WIDTH, 8, width of ast_channel; the value is passed through unchanged.
- RX_DIR, 4, number of input streams, at least 2.
- DIR_SEL_WIDTH, 2, width of the source-index output; equals clog2(RX_DIR).

Ports:
- clk  input  1  single clock.
- srst  input  1  synchronous reset, active-high.
- ast_data_i  input  RX_DIR x DATA_WIDTH  per-input data.
- ast_startofpacket_i  input  RX_DIR  per-input SOP.
- ast_endofpacket_i  input  RX_DIR  per-input EOP.
- ast_valid_i  input  RX_DIR  per-input valid.
- ast_empty_i  input  RX_DIR x EMPTY_WIDTH  per-input empty.
- ast_channel_i  input  RX_DIR x CHANNEL_WIDTH  per-input channel.
- ast_ready_o  output  RX_DIR  per-input ready.
- ast_data_o  output  DATA_WIDTH  merged data.
- ast_startofpacket_o  output  1  merged SOP.
- ast_endofpacket_o  output  1  merged EOP.
- ast_valid_o  output  1  merged valid.
- ast_empty_o  output  EMPTY_WIDTH  merged empty.
- ast_channel_o  output  CHANNEL_WIDTH  channel of the current beat.
- dir_o  output  DIR_SEL_WIDTH  index of the input that supplied the current output beat.
- ast_ready_i  input  1  downstream ready.

Behaviour:
- Transfer rule: a beat moves on any port when valid and ready are both high at a rising edge of clk.
- Reset: while srst is high at a clock edge, the block clears to a known state.
  - All outputs go to 0 on the next edge; ast_ready_o = 0.
  - State = IDLE; last_grant = RX_DIR-1, so input 0 has first priority after reset.
  - Reset mid-packet abandons that packet; no EOP is emitted for it.
- FSM state IDLE:
  - Candidates are inputs with ast_valid_i[i] && ast_startofpacket_i[i].
  - Pick the first candidate scanning last_grant+1, last_grant+2, ... modulo RX_DIR.
  - On a pick: sel = i, last_grant = i, go to BUSY on the next edge. This costs 1 bubble cycle per packet.
  - No beat is accepted in the IDLE cycle, except for malformed beats (next bullet).
  - Any input with valid high and SOP low in IDLE is malformed. Its ast_ready_o is set to 1 and the beat is discarded.
- FSM state BUSY:
  - ast_ready_o[sel] = !ast_valid_o || ast_ready_i. All other ready bits are 0.
  - On an accepted input beat, the output register loads the data, SOP, EOP, empty and channel fields from input sel. It also sets dir_o = sel and ast_valid_o = 1.
  - If the accepted beat has EOP, go to IDLE on the next edge.
  - A single-beat packet (SOP and EOP together) is valid: BUSY lasts 1 cycle.
- Output register:
  - Holds its contents while ast_valid_o && !ast_ready_i.
  - Clears ast_valid_o when the output beat is accepted and no new beat is loaded.
  - Latency from input accept to ast_valid_o is 1 cycle.
  - Full throughput with ast_ready_i held high: 1 beat per cycle within a packet.
- ast_empty_o: carries the input's empty value on EOP beats and is forced to 0 on all other beats.
- Simultaneous events:
  - An EOP acceptance and a waiting SOP on another input in the same cycle: the new grant is evaluated in the following IDLE cycle.
  - ast_ready_i low during an EOP beat: the FSM still returns to IDLE once the beat is taken into the output register.
  - A new packet may be arbitrated while the previous EOP is still held. Its first beat is not accepted until the output register is free.
- Packet ordering: packets from different inputs never interleave on the output. Data and channel pass through unmodified.

Test Plan:
- Reset, then input 0 sends a 3-beat packet (D0..D2, empty=5, channel 0x11) with ast_ready_i=1 → output shows D0..D2 on consecutive cycles with SOP on D0, EOP and empty=5 on D2, and dir_o=0 throughout.
- Inputs 1 and 3 both present SOP in IDLE with last_grant=1 → input 3 is served first, then input 1. dir_o sequence is 3 then 1, with no interleaving.
- All 4 inputs hold single-beat packets continuously → grant order is 0,1,2,3,0,... and each packet takes 2 cycles (IDLE + BUSY).
- ast_ready_i toggles 1,0,0,1 mid-packet → the output beat is held stable while ready is low, and no input beat is lost or duplicated.
- Input 2 drives valid without SOP while the block is IDLE → ast_ready_o[2]=1, the beat is dropped, and no output beat appears.
- srst asserted on beat 2 of a 4-beat packet → on the next cycle all outputs are 0 and the state is IDLE. After release, input 0 wins first.
